// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a one-hot grant decoded from a
// registered index, tenure capped at MAX_HOLD cycles with a timeout pulse.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_to, w_to_nxt;

  logic       w_found;
  logic [1:0] w_winner;
  logic [1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_cand   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_valid_nxt = r_valid;
    w_to_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = 8'd1;
          w_ptr_nxt   = w_winner + 2'd1;
        end
      end
      S_GRANT: begin
        // A dropped request wins over the hold limit: no timeout in that case.
        if (!req[r_idx]) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end else if (r_hold == 8'(MAX_HOLD)) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_to_nxt    = 1'b1;
        end else begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_idx   <= 2'd0;
      r_hold  <= 8'd0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
      r_valid <= w_valid_nxt;
      r_to    <= w_to_nxt;
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (r_valid) gnt[r_idx] = 1'b1;
  end

  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_to;

endmodule
